// File: rtl/raybox_trace_pkg.sv
// raybox_trace_pkg: shared geometry defaults and entry types for the column trace store
// Provides default column count and field widths, wall-side encodings and the packed
// {height, side} trace entry used between the tracer and the renderer.
package raybox_trace_pkg;
    localparam int TRACE_COLUMNS  = 640;
    localparam int TRACE_COL_W    = 10;
    localparam int TRACE_HEIGHT_W = 8;
    localparam int TRACE_SIDE_W   = 1;
    localparam logic SIDE_EW = 1'b0;
    localparam logic SIDE_NS = 1'b1;
    typedef struct packed {
        logic [TRACE_HEIGHT_W-1:0] height;
        logic [TRACE_SIDE_W-1:0]   side;
    } trace_entry_t;
endpackage

// File: rtl/trace_bank_ram.sv
// trace_bank_ram: one bank of the trace store, simple dual-port RAM
// Ports: clk; wr_en_i/wr_addr_i/wr_data_i synchronous write port;
//        rd_en_i/rd_addr_i read request, rd_data_o registered read data (holds when idle).
module trace_bank_ram #(
    parameter int DEPTH = 640,
    parameter int AW    = 10,
    parameter int DW    = 9
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;
    always_ff @(posedge clk) begin
        if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_q <= mem[rd_addr_i];
    end
    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/trace_buffer_pingpong.sv
// trace_buffer_pingpong: double-buffered per-column trace store (tracer writes back, renderer reads front)
// Ports: clk, reset (sync, active-high);
//        wr_en/wr_column/wr_height/wr_side  tracer write into the back bank;
//        rd_en/rd_column -> rd_height/rd_side/rd_valid  1-cycle registered read of the front bank;
//        swap  toggles front/back; front_bank, back_full, front_stale, wr_err status.
module trace_buffer_pingpong
    import raybox_trace_pkg::*;
#(
    parameter int COLUMNS  = TRACE_COLUMNS,
    parameter int COL_W    = TRACE_COL_W,
    parameter int HEIGHT_W = TRACE_HEIGHT_W,
    parameter int SIDE_W   = TRACE_SIDE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [COL_W-1:0]    wr_column,
    input  logic [HEIGHT_W-1:0] wr_height,
    input  logic [SIDE_W-1:0]   wr_side,
    input  logic                rd_en,
    input  logic [COL_W-1:0]    rd_column,
    output logic [HEIGHT_W-1:0] rd_height,
    output logic [SIDE_W-1:0]   rd_side,
    output logic                rd_valid,
    input  logic                swap,
    output logic                front_bank,
    output logic                back_full,
    output logic                front_stale,
    output logic                wr_err
);
    localparam int DW    = HEIGHT_W + SIDE_W;
    localparam int CNT_W = $clog2(COLUMNS + 1);
    localparam logic [COL_W:0]   COL_LIM = (COL_W + 1)'(COLUMNS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COLUMNS);

    logic             front_q, front_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stale_q, stale_d;
    logic             err_q, err_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_sel_q, rd_sel_d;
    logic             rd_zero_q, rd_zero_d;
    logic             wr_in, rd_in, wr_ok, rd_ok;
    logic [DW-1:0]    rd_data0, rd_data1, rd_word;

    assign wr_in = {1'b0, wr_column} < COL_LIM;
    assign rd_in = {1'b0, rd_column} < COL_LIM;
    assign wr_ok = wr_en & wr_in & ~reset;
    assign rd_ok = rd_en & rd_in & ~reset;
    assign back_full = cnt_q == CNT_MAX;

    // The back bank is always the one not being read.
    trace_bank_ram #(.DEPTH(COLUMNS), .AW(COL_W), .DW(DW)) u_bank0 (
        .clk(clk), .wr_en_i(wr_ok & front_q), .wr_addr_i(wr_column),
        .wr_data_i({wr_height, wr_side}), .rd_en_i(rd_ok & ~front_q),
        .rd_addr_i(rd_column), .rd_data_o(rd_data0)
    );
    trace_bank_ram #(.DEPTH(COLUMNS), .AW(COL_W), .DW(DW)) u_bank1 (
        .clk(clk), .wr_en_i(wr_ok & ~front_q), .wr_addr_i(wr_column),
        .wr_data_i({wr_height, wr_side}), .rd_en_i(rd_ok & front_q),
        .rd_addr_i(rd_column), .rd_data_o(rd_data1)
    );

    // A write in the swap cycle lands in the new front bank, so it never counts.
    always_comb begin
        front_d    = front_q ^ swap;
        cnt_d      = swap ? '0 : (wr_ok && !back_full) ? cnt_q + CNT_W'(1) : cnt_q;
        stale_d    = swap ? !back_full : stale_q;
        err_d      = err_q | (wr_en & ~wr_in);
        rd_valid_d = rd_en;
        rd_sel_d   = rd_en ? front_q : rd_sel_q;
        rd_zero_d  = rd_en ? !rd_in : rd_zero_q;
    end

    // rd_zero_q is set on reset so the read outputs come up as zero without
    // needing a reset on the RAM output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            front_q    <= 1'b0;
            cnt_q      <= '0;
            stale_q    <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            front_q    <= front_d;
            cnt_q      <= cnt_d;
            stale_q    <= stale_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_sel_q   <= rd_sel_d;
            rd_zero_q  <= rd_zero_d;
        end
    end

    assign rd_word     = rd_zero_q ? '0 : rd_sel_q ? rd_data1 : rd_data0;
    assign rd_height   = rd_word[DW-1:SIDE_W];
    assign rd_side     = rd_word[SIDE_W-1:0];
    assign rd_valid    = rd_valid_q;
    assign front_bank  = front_q;
    assign front_stale = stale_q;
    assign wr_err      = err_q;
endmodule
